// File: rtl/usb_speed_ctrl_pkg.sv
// Speed codes shared with the USB front end (same values as defines_usb.v)
// plus a small helper used by the speed sequencer.
package usb_speed_ctrl_pkg;

    localparam logic [1:0] USB_SPEED_AUTO = 2'b00;
    localparam logic [1:0] USB_SPEED_LS   = 2'b01;
    localparam logic [1:0] USB_SPEED_FS   = 2'b10;
    localparam logic [1:0] USB_SPEED_HS   = 2'b11;

    function automatic logic speed_is_valid(input logic [1:0] spd);
        return spd != USB_SPEED_AUTO;
    endfunction

endpackage

// File: rtl/usb_speed_ctrl.sv
// USB speed sequencer: restarts the autodetector, waits for a stable result,
// retries on timeout/instability. Optional macro: USB_SPEED_CTRL_WATCHDOG_EN.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | nothing requested since reset
//   RESTART | one-cycle restart pulse to the detector
//   WAIT    | waiting for a non-AUTO result, timer running
//   SETTLE  | candidate captured, counting consecutive matching cycles
//   LOCKED  | speed published on O_speed
//   FAIL    | retries exhausted or manual AUTO requested
module usb_speed_ctrl
    import usb_speed_ctrl_pkg::*;
#(
    parameter int pTIMER_WIDTH   = 24,
    parameter int pRETRY_WIDTH   = 4,
    parameter int pSETTLE_CYCLES = 8
) (
    input  logic                    fe_clk,
    input  logic                    reset_i,
    input  logic                    I_start,
    input  logic                    I_manual_en,
    input  logic [1:0]              I_manual_speed,
    input  logic [pTIMER_WIDTH-1:0] I_timeout,
    input  logic [pRETRY_WIDTH-1:0] I_max_retries,
    input  logic [1:0]              det_speed_i,
    output logic                    det_restart_o,
    output logic [1:0]              O_speed,
    output logic                    O_busy,
    output logic                    O_locked,
    output logic                    O_fail,
    output logic [pRETRY_WIDTH-1:0] O_retry_count
`ifdef USB_SPEED_CTRL_WATCHDOG_EN
    ,
    output logic                    O_relock_pulse
`endif
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RESTART = 3'd1,
        S_WAIT    = 3'd2,
        S_SETTLE  = 3'd3,
        S_LOCKED  = 3'd4,
        S_FAIL    = 3'd5
    } state_t;

    localparam int SW = $clog2(pSETTLE_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_ONE  = SW'(1);
    localparam logic [SW-1:0] SETTLE_DONE = SW'(pSETTLE_CYCLES);
`ifdef USB_SPEED_CTRL_WATCHDOG_EN
    localparam logic [SW-1:0] SETTLE_LAST = SW'(pSETTLE_CYCLES - 1);
`endif

    state_t                  state_q, state_d;
    logic [1:0]              speed_q, speed_d;
    logic [1:0]              cand_q, cand_d;
    logic [pRETRY_WIDTH-1:0] retry_q, retry_d;
    logic [pTIMER_WIDTH-1:0] timer_q, timer_d;
    logic [SW-1:0]           settle_q, settle_d;
    logic [SW-1:0]           settle_inc;
    logic                    take_retry;
    logic                    take_start;
`ifdef USB_SPEED_CTRL_WATCHDOG_EN
    logic                    manual_q, manual_d;
    logic                    relock_q, relock_d;
`endif

    // One-hot state decodes, also handy as debug probes.
    logic st_idle, st_restart, st_wait, st_settle, st_locked, st_fail;
    assign st_idle    = (state_q == S_IDLE);
    assign st_restart = (state_q == S_RESTART);
    assign st_wait    = (state_q == S_WAIT);
    assign st_settle  = (state_q == S_SETTLE);
    assign st_locked  = (state_q == S_LOCKED);
    assign st_fail    = (state_q == S_FAIL);

    assign settle_inc = settle_q + SETTLE_ONE;

    always_ff @(posedge fe_clk) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            speed_q  <= USB_SPEED_AUTO;
            cand_q   <= USB_SPEED_AUTO;
            retry_q  <= '0;
            timer_q  <= '0;
            settle_q <= '0;
`ifdef USB_SPEED_CTRL_WATCHDOG_EN
            manual_q <= 1'b0;
            relock_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            speed_q  <= speed_d;
            cand_q   <= cand_d;
            retry_q  <= retry_d;
            timer_q  <= timer_d;
            settle_q <= settle_d;
`ifdef USB_SPEED_CTRL_WATCHDOG_EN
            manual_q <= manual_d;
            relock_q <= relock_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        speed_d    = speed_q;
        cand_d     = cand_q;
        retry_d    = retry_q;
        timer_d    = timer_q;
        settle_d   = settle_q;
        take_retry = 1'b0;
        take_start = (st_idle || st_locked || st_fail) && I_start;
`ifdef USB_SPEED_CTRL_WATCHDOG_EN
        manual_d   = manual_q;
        relock_d   = 1'b0;
`endif

        case (state_q)
            S_RESTART: begin
                state_d = S_WAIT;
                timer_d = '0;
            end
            S_WAIT: begin
                // A valid result on the timeout cycle still wins.
                if (speed_is_valid(det_speed_i)) begin
                    state_d  = S_SETTLE;
                    cand_d   = det_speed_i;
                    settle_d = SETTLE_ONE;
                end else if (I_timeout != '0 && timer_q == I_timeout - pTIMER_WIDTH'(1)) begin
                    take_retry = 1'b1;
                end else if (timer_q != '1) begin
                    timer_d = timer_q + pTIMER_WIDTH'(1);
                end
            end
            S_SETTLE: begin
                if (det_speed_i == cand_q) begin
                    settle_d = settle_inc;
                    if (settle_inc == SETTLE_DONE) begin
                        state_d  = S_LOCKED;
                        speed_d  = cand_q;
                        settle_d = '0;
`ifdef USB_SPEED_CTRL_WATCHDOG_EN
                        manual_d = 1'b0;
`endif
                    end
                end else begin
                    take_retry = 1'b1;
                end
            end
`ifdef USB_SPEED_CTRL_WATCHDOG_EN
            S_LOCKED: begin
                // settle_q is reused as the consecutive-mismatch counter.
                if (!I_start && !manual_q) begin
                    if (det_speed_i != speed_q) begin
                        settle_d = settle_inc;
                        if (settle_q == SETTLE_LAST) begin
                            state_d  = S_RESTART;
                            speed_d  = USB_SPEED_AUTO;
                            retry_d  = '0;
                            settle_d = '0;
                            relock_d = 1'b1;
                        end
                    end else begin
                        settle_d = '0;
                    end
                end
            end
`endif
            default: ;
        endcase

        if (take_retry) begin
            if (retry_q == I_max_retries) begin
                state_d = S_FAIL;
            end else begin
                retry_d = retry_q + pRETRY_WIDTH'(1);
                state_d = S_RESTART;
            end
        end

        if (take_start) begin
            retry_d  = '0;
            settle_d = '0;
            speed_d  = USB_SPEED_AUTO;
            if (!I_manual_en) begin
                state_d = S_RESTART;
            end else if (I_manual_speed == USB_SPEED_AUTO) begin
                state_d = S_FAIL;
            end else begin
                state_d = S_LOCKED;
                speed_d = I_manual_speed;
`ifdef USB_SPEED_CTRL_WATCHDOG_EN
                manual_d = 1'b1;
`endif
            end
        end
    end

    assign det_restart_o = st_restart;
    assign O_speed       = speed_q;
    assign O_busy        = st_restart | st_wait | st_settle;
    assign O_locked      = st_locked;
    assign O_fail        = st_fail;
    assign O_retry_count = retry_q;
`ifdef USB_SPEED_CTRL_WATCHDOG_EN
    assign O_relock_pulse = relock_q;
`endif

endmodule

// File: tb/tb_usb_speed_ctrl.sv
// Self-checking bench for usb_speed_ctrl: randomized directed scenarios with
// expected timing derived arithmetically from the sequencing rules.
module tb_usb_speed_ctrl;
    import usb_speed_ctrl_pkg::*;

    localparam int TW     = 24;
    localparam int RW     = 4;
    localparam int SETTLE = 8;

    logic          fe_clk = 1'b0;
    logic          reset_i;
    logic          I_start;
    logic          I_manual_en;
    logic [1:0]    I_manual_speed;
    logic [TW-1:0] I_timeout;
    logic [RW-1:0] I_max_retries;
    logic [1:0]    det_speed_i;
    logic          det_restart_o;
    logic [1:0]    O_speed;
    logic          O_busy;
    logic          O_locked;
    logic          O_fail;
    logic [RW-1:0] O_retry_count;
`ifdef USB_SPEED_CTRL_WATCHDOG_EN
    logic          O_relock_pulse;
    int            relock_seen = 0;
`endif

    int cyc     = 0;
    int n_pass  = 0;
    int n_total = 0;
    int pulses[$];

    usb_speed_ctrl #(
        .pTIMER_WIDTH  (TW),
        .pRETRY_WIDTH  (RW),
        .pSETTLE_CYCLES(SETTLE)
    ) dut (
        .fe_clk        (fe_clk),
        .reset_i       (reset_i),
        .I_start       (I_start),
        .I_manual_en   (I_manual_en),
        .I_manual_speed(I_manual_speed),
        .I_timeout     (I_timeout),
        .I_max_retries (I_max_retries),
        .det_speed_i   (det_speed_i),
        .det_restart_o (det_restart_o),
        .O_speed       (O_speed),
        .O_busy        (O_busy),
        .O_locked      (O_locked),
        .O_fail        (O_fail),
        .O_retry_count (O_retry_count)
`ifdef USB_SPEED_CTRL_WATCHDOG_EN
        ,
        .O_relock_pulse(O_relock_pulse)
`endif
    );

    always #5 fe_clk = ~fe_clk;
    always @(posedge fe_clk) cyc <= cyc + 1;

    // Restart pulses are logged by the cycle number of the edge that raised them.
    always @(negedge fe_clk) begin
        if (det_restart_o === 1'b1) pulses.push_back(cyc);
`ifdef USB_SPEED_CTRL_WATCHDOG_EN
        if (O_relock_pulse === 1'b1) relock_seen++;
`endif
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: observed no finish expected finish before %0d cycles", cyc);
        $fatal(1, "bench time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_speed"},   32'(O_speed), 32'(USB_SPEED_AUTO));
        chk({tag, "_busy"},    32'(O_busy), 0);
        chk({tag, "_locked"},  32'(O_locked), 0);
        chk({tag, "_fail"},    32'(O_fail), 0);
        chk({tag, "_restart"}, 32'(det_restart_o), 0);
        chk({tag, "_retry"},   32'(O_retry_count), 0);
    endtask

    // Called at a negedge; returns the edge number that sampled the start.
    task automatic pulse_start(output int s);
        I_start = 1'b1;
        @(negedge fe_clk);
        I_start = 1'b0;
        s = cyc;
    endtask

    task automatic wait_flag(input bit want_fail, input int bound, output int at);
        at = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge fe_clk);
            if ((want_fail ? O_fail : O_locked) === 1'b1) begin
                at = cyc;
                break;
            end
        end
    endtask

    initial begin
        int s, at, t, r, f, dly, p2;
        logic [1:0] spd, man;

        reset_i        = 1'b1;
        I_start        = 1'b0;
        I_manual_en    = 1'b0;
        I_manual_speed = USB_SPEED_AUTO;
        I_timeout      = '0;
        I_max_retries  = '0;
        det_speed_i    = USB_SPEED_AUTO;
        repeat (3) @(negedge fe_clk);
        chk_reset_outputs("reset");
        reset_i = 1'b0;
        @(negedge fe_clk);

        // Lock after AUTO for a few cycles then a steady speed.
        I_timeout     = '0;
        I_max_retries = RW'($urandom_range(3, 0));
        spd = 2'($urandom_range(3, 1));
        dly = $urandom_range(5, 1);
        pulses.delete();
        pulse_start(s);
        chk("t1_restart_pulse", 32'(det_restart_o), 1);
        chk("t1_busy", 32'(O_busy), 1);
        repeat (dly) @(negedge fe_clk);
        chk("t1_pulse_one_cycle", 32'(det_restart_o), 0);
        det_speed_i = spd;
        repeat (SETTLE - 1) @(negedge fe_clk);
        chk("t1_not_locked_early", 32'(O_locked), 0);
        @(negedge fe_clk);
        chk("t1_locked", 32'(O_locked), 1);
        chk("t1_speed", 32'(O_speed), 32'(spd));
        chk("t1_retry", 32'(O_retry_count), 0);
        chk("t1_busy_after", 32'(O_busy), 0);
        chk("t1_pulse_count", pulses.size(), 1);
        if (pulses.size() > 0) chk("t1_pulse_time", pulses[0], s);

        // Detector stuck at AUTO: every attempt times out.
        t = $urandom_range(100, 20);
        r = $urandom_range(3, 1);
        I_timeout     = TW'(t);
        I_max_retries = RW'(r);
        det_speed_i   = USB_SPEED_AUTO;
        pulses.delete();
        pulse_start(s);
        chk("t2_unlock_on_start", 32'(O_locked), 0);
        chk("t2_speed_auto", 32'(O_speed), 32'(USB_SPEED_AUTO));
        wait_flag(1'b1, (r + 1) * (t + 1) + 20, at);
        chk("t2_fail_time", at, s + (r + 1) * (t + 1));
        chk("t2_pulse_count", pulses.size(), r + 1);
        for (int i = 1; i < pulses.size(); i++)
            chk("t2_pulse_gap", pulses[i] - pulses[i-1], t + 1);
        chk("t2_retry", 32'(O_retry_count), r);
        chk("t2_speed", 32'(O_speed), 32'(USB_SPEED_AUTO));
        chk("t2_busy", 32'(O_busy), 0);

        // Zero extra retries: a single attempt.
        t = $urandom_range(10, 3);
        I_timeout     = TW'(t);
        I_max_retries = '0;
        pulses.delete();
        pulse_start(s);
        chk("t2b_fail_cleared", 32'(O_fail), 0);
        wait_flag(1'b1, t + 10, at);
        chk("t2b_fail_time", at, s + t + 1);
        chk("t2b_pulse_count", pulses.size(), 1);
        chk("t2b_retry", 32'(O_retry_count), 0);

        // Valid result on the exact timeout cycle beats the timeout.
        t = $urandom_range(30, 5);
        I_timeout     = TW'(t);
        I_max_retries = RW'($urandom_range(2, 0));
        spd = 2'($urandom_range(3, 1));
        pulses.delete();
        pulse_start(s);
        repeat (t) @(negedge fe_clk);
        det_speed_i = spd;
        wait_flag(1'b0, SETTLE + 10, at);
        chk("t2c_lock_time", at, s + t + SETTLE);
        chk("t2c_pulse_count", pulses.size(), 1);
        chk("t2c_speed", 32'(O_speed), 32'(spd));
        chk("t2c_retry", 32'(O_retry_count), 0);

        // Candidate flips during settle: retry, then lock on the new speed.
        I_timeout     = '0;
        I_max_retries = RW'($urandom_range(3, 1));
        f = $urandom_range(7, 1);
        det_speed_i = USB_SPEED_AUTO;
        pulses.delete();
        pulse_start(s);
        @(negedge fe_clk);
        det_speed_i = USB_SPEED_FS;
        repeat (f) @(negedge fe_clk);
        det_speed_i = USB_SPEED_LS;
        p2 = s + 2 + f;
        wait_flag(1'b0, 40, at);
        chk("t3_pulse_count", pulses.size(), 2);
        if (pulses.size() > 1) chk("t3_second_pulse", pulses[1], p2);
        chk("t3_lock_time", at, p2 + 1 + SETTLE);
        chk("t3_speed", 32'(O_speed), 32'(USB_SPEED_LS));
        chk("t3_retry", 32'(O_retry_count), 1);

        // Manual override from LOCKED, then manual AUTO.
        man = 2'($urandom_range(3, 1));
        I_manual_en    = 1'b1;
        I_manual_speed = man;
        pulses.delete();
        pulse_start(s);
        chk("t4_locked", 32'(O_locked), 1);
        chk("t4_speed", 32'(O_speed), 32'(man));
        chk("t4_busy", 32'(O_busy), 0);
        det_speed_i = USB_SPEED_AUTO;
        repeat (SETTLE + 4) @(negedge fe_clk);
        chk("t4_manual_holds", 32'(O_locked), 1);
        chk("t4_manual_speed_holds", 32'(O_speed), 32'(man));
        chk("t4_no_restart", pulses.size(), 0);
        I_manual_speed = USB_SPEED_AUTO;
        pulse_start(s);
        chk("t4_fail", 32'(O_fail), 1);
        chk("t4_unlocked", 32'(O_locked), 0);
        chk("t4_speed_auto", 32'(O_speed), 32'(USB_SPEED_AUTO));
        I_manual_speed = USB_SPEED_HS;
        repeat (3) @(negedge fe_clk);
        chk("t4_manual_change_deferred", 32'(O_fail), 1);

        // Start ignored while busy; reset mid-settle aborts.
        I_manual_en = 1'b0;
        I_timeout   = '0;
        pulses.delete();
        pulse_start(s);
        repeat (3) @(negedge fe_clk);
        I_start = 1'b1;
        @(negedge fe_clk);
        I_start = 1'b0;
        repeat (3) @(negedge fe_clk);
        chk("t5_start_ignored", pulses.size(), 1);
        chk("t5_still_busy", 32'(O_busy), 1);
        det_speed_i = USB_SPEED_HS;
        repeat (4) @(negedge fe_clk);
        reset_i = 1'b1;
        @(negedge fe_clk);
        chk_reset_outputs("t5_reset");
        reset_i = 1'b0;
        repeat (SETTLE + 4) @(negedge fe_clk);
        chk("t5_stays_idle", 32'(O_locked), 0);
        chk("t5_no_new_pulse", pulses.size(), 1);

        // Lock at HS, then exercise the LOCKED response to detector drops.
        det_speed_i = USB_SPEED_AUTO;
        pulse_start(s);
        @(negedge fe_clk);
        det_speed_i = USB_SPEED_HS;
        wait_flag(1'b0, SETTLE + 10, at);
        chk("t6_locked_hs", 32'(O_speed), 32'(USB_SPEED_HS));
        det_speed_i = USB_SPEED_AUTO;
        repeat (SETTLE - 1) @(negedge fe_clk);
        det_speed_i = USB_SPEED_HS;
        repeat (10) @(negedge fe_clk);
        chk("t6_glitch_keeps_lock", 32'(O_locked), 1);
`ifdef USB_SPEED_CTRL_WATCHDOG_EN
        chk("t6_no_relock", relock_seen, 0);
        pulses.delete();
        det_speed_i = USB_SPEED_AUTO;
        repeat (SETTLE - 1) @(negedge fe_clk);
        chk("t6_relock_not_early", 32'(O_relock_pulse), 0);
        chk("t6_locked_before_drop", 32'(O_locked), 1);
        @(negedge fe_clk);
        chk("t6_relock_pulse", 32'(O_relock_pulse), 1);
        chk("t6_relock_speed", 32'(O_speed), 32'(USB_SPEED_AUTO));
        chk("t6_relock_unlocked", 32'(O_locked), 0);
        chk("t6_relock_restart", 32'(det_restart_o), 1);
        @(negedge fe_clk);
        chk("t6_relock_one_cycle", 32'(O_relock_pulse), 0);
`else
        det_speed_i = USB_SPEED_AUTO;
        repeat (3 * SETTLE) @(negedge fe_clk);
        chk("t6_lock_ignores_det", 32'(O_locked), 1);
        chk("t6_lock_speed_held", 32'(O_speed), 32'(USB_SPEED_HS));
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
